unified_bus_arbiter: RTL and testbench



---
 rtl/unified_bus_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_unified_bus_arbiter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/unified_bus_arbiter.sv
// Single-outstanding request router: round-robin master arbitration, address decode to
// one of four targets, slave handshake, and error/timeout response back to the granted master.
module unified_bus_arbiter #(
    parameter int NUM_MASTERS    = 9,
    parameter int NUM_SLAVES     = 4,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_MASTERS-1:0]             m_req_valid,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]  m_req_addr,
    input  logic [NUM_MASTERS-1:0]             m_req_we,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0]  m_req_wdata,
    output logic [NUM_MASTERS-1:0]             m_req_ready,
    output logic [NUM_MASTERS-1:0]             m_resp_valid,
    output logic [DATA_WIDTH-1:0]              m_resp_rdata,
    output logic                               m_resp_err,
    output logic                               s_req_valid,
    output logic [NUM_SLAVES-1:0]              s_sel,
    output logic [ADDR_WIDTH-1:0]              s_req_addr,
    output logic                               s_req_we,
    output logic [DATA_WIDTH-1:0]              s_req_wdata,
    input  logic [NUM_SLAVES-1:0]              s_req_ready,
    input  logic [NUM_SLAVES-1:0]              s_resp_valid,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0]   s_resp_rdata,
    input  logic [NUM_SLAVES-1:0]              s_resp_err,
    output logic                               busy
);
    localparam int NM = NUM_MASTERS;
    localparam int AW = ADDR_WIDTH;
    localparam int DW = DATA_WIDTH;
    localparam int PW = (NM > 1) ? $clog2(NM) : 1;
    localparam int TW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_REQ  = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_ERR  = 3'd3;
    localparam logic [2:0] S_RESP = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [PW-1:0] rr_ptr_q, rr_ptr_d;
    logic [PW-1:0] win_q, win_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          we_q, we_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          err_q, err_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          found;
    logic [PW-1:0] winner;
    logic [TW-1:0] tgt;
    logic          timeout;

    function automatic logic decode_hit(input logic [AW-1:0] a);
        return (a < AW'(32'h1000_0000)) ||
               (a >= AW'(32'h1000_0000) && a <= AW'(32'h1000_FFFF)) ||
               (a >= AW'(32'h2000_0000) && a <= AW'(32'h2000_FFFF)) ||
               (a >= AW'(32'h3000_0000) && a <= AW'(32'h3000_FFFF));
    endfunction

    function automatic logic [TW-1:0] decode_tgt(input logic [AW-1:0] a);
        logic [TW-1:0] t;
        t = '0;
        if (a >= AW'(32'h3000_0000))      t = TW'(3);
        else if (a >= AW'(32'h2000_0000)) t = TW'(2);
        else if (a >= AW'(32'h1000_0000)) t = TW'(1);
        return t;
    endfunction

    assign tgt     = decode_tgt(addr_q);
    assign timeout = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        int unsigned idx;
        idx    = 0;
        found  = 1'b0;
        winner = '0;
        for (int unsigned i = 0; i < NM; i++) begin
            idx = 32'(rr_ptr_q) + i;
            if (idx >= NM) idx = idx - NM;
            if (!found && m_req_valid[PW'(idx)]) begin
                found  = 1'b1;
                winner = PW'(idx);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        win_d       = win_q;
        addr_d      = addr_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        cnt_d       = cnt_q;
        m_req_ready = '0;
        case (state_q)
            S_IDLE: begin
                if (found && !rst) begin
                    m_req_ready[winner] = 1'b1;
                    win_d    = winner;
                    addr_d   = m_req_addr[winner*AW +: AW];
                    we_d     = m_req_we[winner];
                    wdata_d  = m_req_wdata[winner*DW +: DW];
                    rr_ptr_d = (winner == PW'(NM - 1)) ? '0 : winner + 1'b1;
                    rdata_d  = '0;
                    err_d    = 1'b0;
                    cnt_d    = '0;
                    state_d  = decode_hit(m_req_addr[winner*AW +: AW]) ? S_REQ : S_ERR;
                end
            end
            S_REQ: begin
                cnt_d = cnt_q + 1'b1;
                if (timeout) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else if (s_req_ready[tgt]) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                // A response arriving on the expiry cycle still counts as completion.
                if (s_resp_valid[tgt]) begin
                    rdata_d = s_resp_rdata[tgt*DW +: DW];
                    err_d   = s_resp_err[tgt];
                    state_d = S_RESP;
                end else if (timeout) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_ERR: begin
                rdata_d = '0;
                err_d   = 1'b1;
                state_d = S_RESP;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        m_resp_valid = '0;
        m_resp_rdata = '0;
        m_resp_err   = 1'b0;
        s_sel        = '0;
        if (!rst && state_q == S_RESP) begin
            m_resp_valid[win_q] = 1'b1;
            m_resp_rdata        = rdata_q;
            m_resp_err          = err_q;
        end
        if (!rst && state_q == S_REQ) s_sel[tgt] = 1'b1;
    end

    assign s_req_valid = !rst && (state_q == S_REQ);
    assign s_req_addr  = addr_q;
    assign s_req_we    = we_q;
    assign s_req_wdata = wdata_q;
    assign busy        = (state_q != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= '0;
            win_q    <= '0;
            addr_q   <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            win_q    <= win_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end
endmodule

// File: tb/tb_unified_bus_arbiter.sv
// Directed bench for unified_bus_arbiter: arbitration order, decode, error and timeout
// responses, and mid-transaction reset.
module tb_unified_bus_arbiter;
    localparam int NM = 9;
    localparam int NS = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NM-1:0]     m_req_valid = '0;
    logic [NM*AW-1:0]  m_req_addr = '0;
    logic [NM-1:0]     m_req_we = '0;
    logic [NM*DW-1:0]  m_req_wdata = '0;
    logic [NM-1:0]     m_req_ready;
    logic [NM-1:0]     m_resp_valid;
    logic [DW-1:0]     m_resp_rdata;
    logic              m_resp_err;
    logic              s_req_valid;
    logic [NS-1:0]     s_sel;
    logic [AW-1:0]     s_req_addr;
    logic              s_req_we;
    logic [DW-1:0]     s_req_wdata;
    logic [NS-1:0]     s_req_ready = '0;
    logic [NS-1:0]     s_resp_valid = '0;
    logic [NS*DW-1:0]  s_resp_rdata = {32'h3333_0003, 32'h2222_0002, 32'h1111_0001, 32'hCAFE_F00D};
    logic [NS-1:0]     s_resp_err = '0;
    logic              busy;

    int          pass_cnt = 0;
    int          total = 0;
    logic        auto_slave = 1'b1;
    logic [NS-1:0] pend_sel = '0;

    unified_bus_arbiter #(
        .NUM_MASTERS(NM), .NUM_SLAVES(NS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .rst(rst),
        .m_req_valid(m_req_valid), .m_req_addr(m_req_addr), .m_req_we(m_req_we),
        .m_req_wdata(m_req_wdata), .m_req_ready(m_req_ready), .m_resp_valid(m_resp_valid),
        .m_resp_rdata(m_resp_rdata), .m_resp_err(m_resp_err), .s_req_valid(s_req_valid),
        .s_sel(s_sel), .s_req_addr(s_req_addr), .s_req_we(s_req_we), .s_req_wdata(s_req_wdata),
        .s_req_ready(s_req_ready), .s_resp_valid(s_resp_valid), .s_resp_rdata(s_resp_rdata),
        .s_resp_err(s_resp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    // Advance one clock; when enabled, act as a slave that accepts at once and responds next cycle.
    task automatic tick();
        @(posedge clk);
        #1;
        if (auto_slave) begin
            s_resp_valid = pend_sel;
            pend_sel     = '0;
            if (s_req_valid) begin
                s_req_ready = s_sel;
                pend_sel    = s_sel;
            end else begin
                s_req_ready = '0;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        m_req_valid[0] = 1'b1;
        #1;
        total++; if (m_req_ready !== 9'h000) $display("FAIL rst_ready: got %h want 000", m_req_ready); else pass_cnt++;
        m_req_valid = '0;
        #1;
        total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else pass_cnt++;
        total++; if (m_resp_valid !== 9'h000) $display("FAIL rst_resp_valid: got %h want 000", m_resp_valid); else pass_cnt++;
        total++; if ({m_resp_rdata, m_resp_err} !== 33'h0) $display("FAIL rst_resp_data: got %h/%b want 0/0", m_resp_rdata, m_resp_err); else pass_cnt++;
        total++; if ({s_req_valid, s_sel} !== 5'h0) $display("FAIL rst_sreq: got %b/%b want 0/0000", s_req_valid, s_sel); else pass_cnt++;
        total++; if ({s_req_addr, s_req_we, s_req_wdata} !== 65'h0) $display("FAIL rst_latched: got %h/%b/%h want 0", s_req_addr, s_req_we, s_req_wdata); else pass_cnt++;
        rst = 1'b0;
    endtask

    task automatic test_single_read();
        m_req_addr[0*AW +: AW] = 32'h0000_0040;
        m_req_we[0]    = 1'b0;
        m_req_valid[0] = 1'b1;
        #1;
        total++; if (m_req_ready !== 9'h001) $display("FAIL rd_ready: got %h want 001", m_req_ready); else pass_cnt++;
        tick();
        m_req_valid = '0;
        total++; if (s_req_valid !== 1'b1 || s_sel !== 4'b0001) $display("FAIL rd_sel: got %b/%b want 1/0001", s_req_valid, s_sel); else pass_cnt++;
        total++; if (s_req_addr !== 32'h0000_0040) $display("FAIL rd_addr: got %h want 00000040", s_req_addr); else pass_cnt++;
        total++; if (busy !== 1'b1 || m_req_ready !== 9'h000) $display("FAIL rd_busy: got %b/%h want 1/000", busy, m_req_ready); else pass_cnt++;
        tick();
        total++; if (m_resp_valid !== 9'h000 || s_req_valid !== 1'b0) $display("FAIL rd_wait: got %h/%b want 000/0", m_resp_valid, s_req_valid); else pass_cnt++;
        tick();
        total++; if (m_resp_valid !== 9'h001) $display("FAIL rd_resp_valid: got %h want 001", m_resp_valid); else pass_cnt++;
        total++; if (m_resp_rdata !== 32'hCAFE_F00D || m_resp_err !== 1'b0) $display("FAIL rd_resp_data: got %h/%b want cafef00d/0", m_resp_rdata, m_resp_err); else pass_cnt++;
        tick();
        total++; if (busy !== 1'b0 || m_resp_valid !== 9'h000) $display("FAIL rd_idle: got %b/%h want 0/000", busy, m_resp_valid); else pass_cnt++;
    endtask

    task automatic test_round_robin();
        int       grants[$];
        int       resp_cnt[NM];
        int       viol;
        int       bad_data;
        int       resp_total;
        logic     drop;
        logic [DW-1:0] exp_d;
        int       exp_order[6];
        exp_order = '{0, 3, 8, 0, 3, 8};
        viol = 0; bad_data = 0; resp_total = 0; drop = 1'b0;
        for (int i = 0; i < NM; i++) resp_cnt[i] = 0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_req_addr[0*AW +: AW] = 32'h0000_0080;
        m_req_addr[3*AW +: AW] = 32'h1000_0010;
        m_req_addr[8*AW +: AW] = 32'h3000_0000;
        m_req_we = '0;
        m_req_valid = 9'b1_0000_1001;
        #1;
        for (int c = 0; c < 80; c++) begin
            if (m_req_ready != '0) begin
                if ($countones(m_req_ready) != 1 || busy) viol++;
                for (int i = 0; i < NM; i++) if (m_req_ready[i]) grants.push_back(i);
                if (grants.size() >= 6) drop = 1'b1;
            end
            if (m_resp_valid != '0) begin
                if ($countones(m_resp_valid) != 1) viol++;
                for (int i = 0; i < NM; i++) begin
                    if (m_resp_valid[i]) begin
                        resp_cnt[i]++;
                        resp_total++;
                        exp_d = (i == 0) ? 32'hCAFE_F00D : (i == 3) ? 32'h1111_0001 : 32'h3333_0003;
                        if (m_resp_rdata !== exp_d || m_resp_err !== 1'b0) bad_data++;
                    end
                end
            end
            if (resp_total >= 6) break;
            tick();
            if (drop) m_req_valid = '0;
        end
        tick();
        total++; if (grants.size() != 6) $display("FAIL rr_grant_count: got %0d want 6", grants.size()); else pass_cnt++;
        for (int k = 0; k < 6 && k < grants.size(); k++) begin
            total++; if (grants[k] != exp_order[k]) $display("FAIL rr_order[%0d]: got %0d want %0d", k, grants[k], exp_order[k]); else pass_cnt++;
        end
        total++; if (resp_cnt[0] != 2 || resp_cnt[3] != 2 || resp_cnt[8] != 2) $display("FAIL rr_resp_count: got %0d/%0d/%0d want 2/2/2", resp_cnt[0], resp_cnt[3], resp_cnt[8]); else pass_cnt++;
        total++; if (viol != 0) $display("FAIL rr_onehot: got %0d violations want 0", viol); else pass_cnt++;
        total++; if (bad_data != 0) $display("FAIL rr_rdata: got %0d bad responses want 0", bad_data); else pass_cnt++;
    endtask

    task automatic test_unmapped();
        m_req_addr[2*AW +: AW]  = 32'h4000_0000;
        m_req_wdata[2*DW +: DW] = 32'hDEAD_BEEF;
        m_req_we[2]    = 1'b1;
        m_req_valid[2] = 1'b1;
        #1;
        total++; if (m_req_ready !== 9'h004) $display("FAIL um_ready: got %h want 004", m_req_ready); else pass_cnt++;
        tick();
        m_req_valid = '0;
        m_req_we    = '0;
        total++; if (s_req_valid !== 1'b0 || s_sel !== 4'b0000 || busy !== 1'b1) $display("FAIL um_no_sreq: got %b/%b/%b want 0/0000/1", s_req_valid, s_sel, busy); else pass_cnt++;
        total++; if (s_req_we !== 1'b1 || s_req_wdata !== 32'hDEAD_BEEF) $display("FAIL um_latch: got %b/%h want 1/deadbeef", s_req_we, s_req_wdata); else pass_cnt++;
        tick();
        total++; if (m_resp_valid !== 9'h004 || m_resp_err !== 1'b1 || m_resp_rdata !== 32'h0) $display("FAIL um_resp: got %h/%b/%h want 004/1/0", m_resp_valid, m_resp_err, m_resp_rdata); else pass_cnt++;
        tick();
        total++; if (busy !== 1'b0) $display("FAIL um_idle: got %b want 0", busy); else pass_cnt++;
    endtask

    task automatic test_decode_boundary();
        m_req_addr[1*AW +: AW] = 32'h2000_FFFC;
        m_req_valid[1] = 1'b1;
        #1;
        total++; if (m_req_ready !== 9'h002) $display("FAIL db_ready_a: got %h want 002", m_req_ready); else pass_cnt++;
        tick();
        m_req_valid = '0;
        total++; if (s_req_valid !== 1'b1 || s_sel !== 4'b0100) $display("FAIL db_sel: got %b/%b want 1/0100", s_req_valid, s_sel); else pass_cnt++;
        tick();
        tick();
        total++; if (m_resp_valid !== 9'h002 || m_resp_rdata !== 32'h2222_0002 || m_resp_err !== 1'b0) $display("FAIL db_resp_a: got %h/%h/%b want 002/22220002/0", m_resp_valid, m_resp_rdata, m_resp_err); else pass_cnt++;
        tick();
        m_req_addr[1*AW +: AW] = 32'h2001_0000;
        m_req_valid[1] = 1'b1;
        #1;
        total++; if (m_req_ready !== 9'h002) $display("FAIL db_ready_b: got %h want 002", m_req_ready); else pass_cnt++;
        tick();
        m_req_valid = '0;
        total++; if (s_req_valid !== 1'b0) $display("FAIL db_miss_sreq: got %b want 0", s_req_valid); else pass_cnt++;
        tick();
        total++; if (m_resp_valid !== 9'h002 || m_resp_err !== 1'b1 || m_resp_rdata !== 32'h0) $display("FAIL db_resp_b: got %h/%b/%h want 002/1/0", m_resp_valid, m_resp_err, m_resp_rdata); else pass_cnt++;
        tick();
    endtask

    task automatic test_timeout();
        int k;
        auto_slave   = 1'b0;
        s_req_ready  = '0;
        s_resp_valid = '0;
        m_req_addr[5*AW +: AW] = 32'h1000_0000;
        m_req_valid[5] = 1'b1;
        #1;
        total++; if (m_req_ready !== 9'h020) $display("FAIL to_ready: got %h want 020", m_req_ready); else pass_cnt++;
        tick();
        m_req_valid = '0;
        total++; if (s_req_valid !== 1'b1 || s_sel !== 4'b0010) $display("FAIL to_sel: got %b/%b want 1/0010", s_req_valid, s_sel); else pass_cnt++;
        s_req_ready = 4'b0010;
        k = 0;
        while (k < 40) begin
            tick();
            k++;
            if (k == 1) s_req_ready = '0;
            if (m_resp_valid !== 9'h000) break;
        end
        total++; if (k != 16) $display("FAIL to_latency: got %0d cycles want 16", k); else pass_cnt++;
        total++; if (m_resp_valid !== 9'h020 || m_resp_err !== 1'b1 || m_resp_rdata !== 32'h0) $display("FAIL to_resp: got %h/%b/%h want 020/1/0", m_resp_valid, m_resp_err, m_resp_rdata); else pass_cnt++;
        tick();
        s_resp_valid = 4'b0010;
        tick();
        total++; if (m_resp_valid !== 9'h000 || busy !== 1'b0) $display("FAIL to_late_resp: got %h/%b want 000/0", m_resp_valid, busy); else pass_cnt++;
        s_resp_valid = '0;
        tick();
        total++; if (m_resp_valid !== 9'h000) $display("FAIL to_late_resp2: got %h want 000", m_resp_valid); else pass_cnt++;
        auto_slave = 1'b1;
    endtask

    task automatic test_reset_abort();
        auto_slave = 1'b0;
        m_req_addr[5*AW +: AW] = 32'h0000_0100;
        m_req_valid[5] = 1'b1;
        #1;
        total++; if (m_req_ready !== 9'h020) $display("FAIL ra_ready: got %h want 020", m_req_ready); else pass_cnt++;
        tick();
        m_req_valid = '0;
        s_req_ready = 4'b0001;
        tick();
        s_req_ready = '0;
        total++; if (busy !== 1'b1 || s_req_valid !== 1'b0) $display("FAIL ra_wait: got %b/%b want 1/0", busy, s_req_valid); else pass_cnt++;
        tick();
        rst = 1'b1;
        s_resp_valid = 4'b0001;
        tick();
        total++; if (busy !== 1'b0 || m_resp_valid !== 9'h000 || s_req_valid !== 1'b0) $display("FAIL ra_reset: got %b/%h/%b want 0/000/0", busy, m_resp_valid, s_req_valid); else pass_cnt++;
        total++; if ({s_req_addr, m_resp_rdata, m_resp_err} !== 65'h0) $display("FAIL ra_reset_regs: got %h/%h/%b want 0", s_req_addr, m_resp_rdata, m_resp_err); else pass_cnt++;
        rst = 1'b0;
        tick();
        total++; if (m_resp_valid !== 9'h000 || busy !== 1'b0) $display("FAIL ra_no_resp: got %h/%b want 000/0", m_resp_valid, busy); else pass_cnt++;
        s_resp_valid = '0;
        auto_slave   = 1'b1;
        m_req_addr[4*AW +: AW] = 32'h2000_0010;
        m_req_addr[8*AW +: AW] = 32'h0000_0000;
        m_req_valid = 9'b1_0001_0000;
        #1;
        total++; if (m_req_ready !== 9'h010) $display("FAIL ra_rr_ptr: got %h want 010", m_req_ready); else pass_cnt++;
        tick();
        m_req_valid = '0;
        tick();
        tick();
        total++; if (m_resp_valid !== 9'h010 || m_resp_rdata !== 32'h2222_0002) $display("FAIL ra_new_resp: got %h/%h want 010/22220002", m_resp_valid, m_resp_rdata); else pass_cnt++;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_unmapped();
        test_decode_boundary();
        test_timeout();
        test_reset_abort();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
